// File: rtl/sim_sweep_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sim_sweep_scheduler_pkg
//  Description : Shared geometry defaults and sweep FSM state encoding for the
//                raster-sweep scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sim_sweep_scheduler_pkg;

    localparam int X_bits     = 8;
    localparam int Y_bits     = 8;
    localparam int X_MAX      = 159;
    localparam int Y_MAX      = 119;
    localparam int PIPE_DEPTH = 2;
    localparam int FRAME_bits = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_SWEEP = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/sim_sweep_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_sweep_scheduler_if
//  Description : Control and location bus between the simulation top and the
//                sweep scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_sweep_scheduler_if #(
    parameter int X_bits     = sim_sweep_scheduler_pkg::X_bits,
    parameter int Y_bits     = sim_sweep_scheduler_pkg::Y_bits,
    parameter int FRAME_bits = sim_sweep_scheduler_pkg::FRAME_bits
);
    logic                  game_tick;
    logic                  RUN;
    logic                  PAUSE;
    logic                  STEP;
    logic                  hold;
    logic                  clear_overrun;
    logic [X_bits-1:0]     viewLoc_x;
    logic [Y_bits-1:0]     viewLoc_y;
    logic [X_bits-1:0]     writeLoc_x;
    logic [Y_bits-1:0]     writeLoc_y;
    logic                  write_flag;
    logic                  sweep_busy;
    logic                  sweep_done;
    logic [FRAME_bits-1:0] frame_count;
    logic                  overrun;

    modport master (
        output game_tick, RUN, PAUSE, STEP, hold, clear_overrun,
        input  viewLoc_x, viewLoc_y, writeLoc_x, writeLoc_y,
        input  write_flag, sweep_busy, sweep_done, frame_count, overrun
    );

    modport slave (
        input  game_tick, RUN, PAUSE, STEP, hold, clear_overrun,
        output viewLoc_x, viewLoc_y, writeLoc_x, writeLoc_y,
        output write_flag, sweep_busy, sweep_done, frame_count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sim_sweep_scheduler_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : x/y raster wrap counter. x runs 0..X_MAX, then y steps;
//                after (X_MAX,Y_MAX) both return to 0 and wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter int X_bits = sim_sweep_scheduler_pkg::X_bits,
    parameter int Y_bits = sim_sweep_scheduler_pkg::Y_bits,
    parameter int X_MAX  = sim_sweep_scheduler_pkg::X_MAX,
    parameter int Y_MAX  = sim_sweep_scheduler_pkg::Y_MAX
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic              clr,
    output logic [X_bits-1:0]      x,
    output logic [Y_bits-1:0]      y,
    output logic                   wrap
);
    import sim_sweep_scheduler_pkg::*;

    localparam logic [X_bits-1:0] c_X_LAST = X_bits'(X_MAX);
    localparam logic [Y_bits-1:0] c_Y_LAST = Y_bits'(Y_MAX);

    logic [X_bits-1:0] r_x;
    logic [Y_bits-1:0] r_y;
    logic              w_x_last;
    logic              w_y_last;

    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);
    assign wrap     = en & w_x_last & w_y_last;
    assign x        = r_x;
    assign y        = r_y;

    // Advance one cell in raster order when enabled; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sim_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sim_sweep_scheduler
//  Description : Launches one raster sweep per accepted tick. The view counter
//                leads the write counter by PIPE_DEPTH cells; supports pause,
//                single-step, stall (hold) and sticky overrun reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_sweep_scheduler #(
    parameter int X_bits     = sim_sweep_scheduler_pkg::X_bits,
    parameter int Y_bits     = sim_sweep_scheduler_pkg::Y_bits,
    parameter int X_MAX      = sim_sweep_scheduler_pkg::X_MAX,
    parameter int Y_MAX      = sim_sweep_scheduler_pkg::Y_MAX,
    parameter int PIPE_DEPTH = sim_sweep_scheduler_pkg::PIPE_DEPTH,
    parameter int FRAME_bits = sim_sweep_scheduler_pkg::FRAME_bits
) (
    input  wire logic              newLocClock,
    input  wire logic              RESET_SIM,
    sim_sweep_scheduler_if.slave   bus
);
    import sim_sweep_scheduler_pkg::*;

    // Last value of the prime counter before the sweep proper begins.
    localparam logic [2:0] c_DEPTH_LAST = 3'(PIPE_DEPTH - 1);

    sweep_state_t          r_state;
    sweep_state_t          w_state_next;
    logic [2:0]            r_depth;
    logic [2:0]            w_depth_next;
    logic [FRAME_bits-1:0] r_frame;
    logic                  r_overrun;
    logic                  w_launch;
    logic                  w_overrun_set;
    logic                  w_view_en;
    logic                  w_write_en;
    logic                  w_clr;
    logic                  w_view_wrap;
    logic                  w_write_wrap;

    // A launch needs RUN, no stall, and a tick or step matching PAUSE.
    assign w_launch = (r_state == S_IDLE) & bus.RUN & ~bus.hold &
                      ((bus.game_tick & ~bus.PAUSE) | (bus.STEP & bus.PAUSE));

    // Any request outside IDLE (DONE included) is dropped and flagged.
    assign w_overrun_set = (bus.game_tick | bus.STEP) & (r_state != S_IDLE);

    raster_counter #(
        .X_bits (X_bits), .Y_bits (Y_bits), .X_MAX (X_MAX), .Y_MAX (Y_MAX)
    ) u_view (
        .clk  (newLocClock), .rst (RESET_SIM), .en (w_view_en), .clr (w_clr),
        .x    (bus.viewLoc_x), .y (bus.viewLoc_y), .wrap (w_view_wrap)
    );

    raster_counter #(
        .X_bits (X_bits), .Y_bits (Y_bits), .X_MAX (X_MAX), .Y_MAX (Y_MAX)
    ) u_write (
        .clk  (newLocClock), .rst (RESET_SIM), .en (w_write_en), .clr (w_clr),
        .x    (bus.writeLoc_x), .y (bus.writeLoc_y), .wrap (w_write_wrap)
    );

    // State and prime-depth registers.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_state <= S_IDLE;
            r_depth <= '0;
        end else begin
            r_state <= w_state_next;
            r_depth <= w_depth_next;
        end
    end

    // Next-state and counter enables; a held cycle leaves everything frozen.
    always_comb begin
        w_state_next = r_state;
        w_depth_next = r_depth;
        w_view_en    = 1'b0;
        w_write_en   = 1'b0;
        w_clr        = 1'b0;
        if (!bus.hold) begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        w_state_next = S_PRIME;
                        w_depth_next = '0;
                        w_clr        = 1'b1;
                    end
                end
                S_PRIME: begin
                    w_view_en = 1'b1;
                    if (r_depth == c_DEPTH_LAST) begin
                        w_state_next = S_SWEEP;
                        w_depth_next = '0;
                    end else begin
                        w_depth_next = r_depth + 3'd1;
                    end
                end
                S_SWEEP: begin
                    w_view_en  = 1'b1;
                    w_write_en = 1'b1;
                    if (w_view_wrap) begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_write_en = 1'b1;
                    if (w_write_wrap) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Completed-sweep counter; a held DONE waits for the stall to clear.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_frame <= '0;
        end else if ((r_state == S_DONE) && !bus.hold) begin
            r_frame <= r_frame + 1'b1;
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (bus.clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.write_flag  = w_write_en;
    assign bus.sweep_busy  = (r_state != S_IDLE);
    assign bus.sweep_done  = (r_state == S_DONE) & ~bus.hold;
    assign bus.frame_count = r_frame;
    assign bus.overrun     = r_overrun;
endmodule
`default_nettype wire
